// File: rtl/disp_scan.sv
// ============================================================================
// disp_scan : multiplexed hex seven-segment scan controller with frame-
//             synchronous value update, dead time and leading-zero blanking
// Rev 1.0
// ============================================================================
`default_nettype none

module disp_scan #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 1024,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic [3:0]            nibble,
   output logic                  dp,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame
);

   localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIW = $clog2(DIGITS);
   localparam logic [PCW-1:0] C_PC_LAST = PCW'(PRESCALE - 1);
   localparam logic [DIW-1:0] C_DI_LAST = DIW'(DIGITS - 1);

   logic [PCW-1:0]      pc_q, pc_d;
   logic [DIW-1:0]      di_q, di_d;
   logic [4*DIGITS-1:0] sh_val_q, sh_val_d;
   logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic                pend_q, pend_d;
   logic [4*DIGITS-1:0] act_val_q, act_val_d;
   logic [DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [3:0]          nibble_q, nibble_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic                frame_q, frame_d;

   logic                w_slot_end;
   logic                w_wrap;
   logic                w_zero_run;
   logic [DIGITS-1:0]   w_lz_blank;

   always_comb begin
      pc_d       = pc_q;
      di_d       = di_q;
      sh_val_d   = sh_val_q;
      sh_dp_d    = sh_dp_q;
      pend_d     = pend_q;
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      nibble_d   = nibble_q;
      dp_d       = dp_q;
      en_d       = '0;
      frame_d    = 1'b0;
      w_zero_run = 1'b1;
      w_lz_blank = '0;

      w_slot_end = (pc_q == C_PC_LAST);
      w_wrap     = w_slot_end && (di_q == C_DI_LAST);

      pc_d = w_slot_end ? '0 : pc_q + PCW'(1);
      if (w_slot_end) begin
         di_d = (di_q == C_DI_LAST) ? '0 : di_q + DIW'(1);
      end

      // A load on the wrap cycle bypasses the shadow straight into the active set.
      if (w_wrap) begin
         if (load) begin
            act_val_d = value;
            act_dp_d  = dp_in;
            pend_d    = 1'b0;
         end else if (pend_q) begin
            act_val_d = sh_val_q;
            act_dp_d  = sh_dp_q;
            pend_d    = 1'b0;
         end
      end else if (load) begin
         sh_val_d = value;
         sh_dp_d  = dp_in;
         pend_d   = 1'b1;
      end

      if (w_slot_end) begin
         nibble_d = act_val_d[{di_d, 2'b00} +: 4];
         dp_d     = act_dp_d[di_d];
      end

      // Walk down from the top digit; digit 0 is never part of the blank run.
      for (int k = DIGITS - 1; k >= 1; k--) begin
         w_zero_run    = w_zero_run & (act_val_d[4*k +: 4] == 4'h0);
         w_lz_blank[k] = w_zero_run & ~act_dp_d[k];
      end

      if ((int'(pc_d) >= BLANK_CYCLES) && !(blank_lz && w_lz_blank[di_d])) begin
         en_d = DIGITS'(1) << di_d;
      end

      frame_d = (pc_d == C_PC_LAST) && (di_d == C_DI_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= '0;
         di_q      <= '0;
         sh_val_q  <= '0;
         sh_dp_q   <= '0;
         pend_q    <= 1'b0;
         act_val_q <= '0;
         act_dp_q  <= '0;
         nibble_q  <= '0;
         dp_q      <= 1'b0;
         en_q      <= '0;
         frame_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         di_q      <= di_d;
         sh_val_q  <= sh_val_d;
         sh_dp_q   <= sh_dp_d;
         pend_q    <= pend_d;
         act_val_q <= act_val_d;
         act_dp_q  <= act_dp_d;
         nibble_q  <= nibble_d;
         dp_q      <= dp_d;
         en_q      <= en_d;
         frame_q   <= frame_d;
      end
   end

   assign nibble   = nibble_q;
   assign dp       = dp_q;
   assign digit_en = en_q;
   assign frame    = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan.sv
// ============================================================================
// tb_disp_scan : self-checking bench for disp_scan (DIGITS=4, PRESCALE=8,
//                BLANK_CYCLES=2)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_disp_scan;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic        load;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic [3:0]  nibble;
   logic        dp;
   logic [3:0]  digit_en;
   logic        frame;

   disp_scan #(
      .DIGITS       (4),
      .PRESCALE     (8),
      .BLANK_CYCLES (2)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .value    (value),
      .load     (load),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .nibble   (nibble),
      .dp       (dp),
      .digit_en (digit_en),
      .frame    (frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          t;
      logic [15:0] v;
      logic [3:0]  d;
   } load_t;

   typedef struct {
      int         cyc;
      logic       blz;
      logic [3:0] en;
      logic       fr;
   } vec_t;

   load_t lq[$];
   int    t;
   logic  blz_prev;
   logic  blz_lvl;
   int    n_cmp;
   int    n_bad;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
      n_cmp++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s t=%0d: got 0x%0h, required 0x%0h", name, t, got, req);
      end
   endtask

   // Displayed frame f holds the most recent load made no later than the
   // last cycle of frame f-1; a digit slot is 8 cycles, a frame 32.
   task automatic check_model();
      int          f, di, pc;
      logic [15:0] av;
      logic [3:0]  ad;
      logic [3:0]  en;
      f  = t / 32;
      di = (t / 8) % 4;
      pc = t % 8;
      av = 16'h0;
      ad = 4'h0;
      foreach (lq[i]) begin
         if (lq[i].t <= 32 * f - 1) begin
            av = lq[i].v;
            ad = lq[i].d;
         end
      end
      en = 4'b0001 << di;
      if (pc < 2) en = 4'b0000;
      else if (blz_prev && di != 0 && (av >> (4 * di)) == 16'h0 && !ad[di]) en = 4'b0000;
      cmp("model_nibble", nibble, av[4*di +: 4]);
      cmp("model_dp", dp, ad[di]);
      cmp("model_digit_en", digit_en, en);
      cmp("model_frame", frame, (t % 32) == 31);
   endtask

   task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic blz);
      load     = ld;
      value    = v;
      dp_in    = d;
      blank_lz = blz;
      if (ld) lq.push_back('{t, v, d});
      blz_prev = blz;
      @(posedge clk);
      #1;
      t++;
      load = 1'b0;
      check_model();
   endtask

   task automatic run_to(input int tt);
      while (t < tt) step(1'b0, 16'h0, 4'h0, blz_lvl);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      load     = 1'b0;
      value    = 16'h0;
      dp_in    = 4'h0;
      blank_lz = blz_lvl;
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_nibble", nibble, 4'h0);
      cmp("rst_dp", dp, 1'b0);
      cmp("rst_digit_en", digit_en, 4'h0);
      cmp("rst_frame", frame, 1'b0);
      rst_n = 1'b1;
      lq.delete();
      t        = 0;
      blz_prev = blz_lvl;
      check_model();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t       tbl[17];
      logic [3:0] exp_nib[4];
      logic [3:0] en_seen;
      logic       bad;

      tbl[0]  = '{0,   1'b0, 4'b0000, 1'b0};
      tbl[1]  = '{1,   1'b0, 4'b0000, 1'b0};
      tbl[2]  = '{2,   1'b0, 4'b0001, 1'b0};
      tbl[3]  = '{7,   1'b0, 4'b0001, 1'b0};
      tbl[4]  = '{8,   1'b0, 4'b0000, 1'b0};
      tbl[5]  = '{9,   1'b0, 4'b0000, 1'b0};
      tbl[6]  = '{10,  1'b0, 4'b0010, 1'b0};
      tbl[7]  = '{15,  1'b0, 4'b0010, 1'b0};
      tbl[8]  = '{26,  1'b0, 4'b1000, 1'b0};
      tbl[9]  = '{31,  1'b0, 4'b1000, 1'b1};
      tbl[10] = '{32,  1'b0, 4'b0000, 1'b0};
      tbl[11] = '{63,  1'b0, 4'b1000, 1'b1};
      tbl[12] = '{66,  1'b1, 4'b0001, 1'b0};
      tbl[13] = '{74,  1'b1, 4'b0000, 1'b0};
      tbl[14] = '{95,  1'b1, 4'b0000, 1'b1};
      tbl[15] = '{106, 1'b0, 4'b0010, 1'b0};
      tbl[16] = '{107, 1'b1, 4'b0000, 1'b0};

      n_cmp   = 0;
      n_bad   = 0;
      t       = 0;
      blz_lvl = 1'b0;
      do_reset();

      foreach (tbl[i]) begin
         blz_lvl = tbl[i].blz;
         run_to(tbl[i].cyc);
         cmp("tbl_digit_en", digit_en, tbl[i].en);
         cmp("tbl_frame", frame, tbl[i].fr);
      end
      blz_lvl = 1'b0;
      run_to(108);
      cmp("blank_release_en", digit_en, 4'b0010);

      // Mid-frame load shows only from the next frame on.
      run_to(110);
      step(1'b1, 16'hA3F1, 4'b0100, blz_lvl);
      run_to(127);
      cmp("a3f1_not_yet", nibble, 4'h0);
      exp_nib[0] = 4'h1;
      exp_nib[1] = 4'hF;
      exp_nib[2] = 4'h3;
      exp_nib[3] = 4'hA;
      for (int s = 0; s < 4; s++) begin
         run_to(128 + 8 * s + 3);
         cmp("a3f1_nibble", nibble, exp_nib[s]);
         cmp("a3f1_dp", dp, s == 2);
      end

      // Two loads in one frame: last write wins.
      run_to(165);
      step(1'b1, 16'h1111, 4'h0, blz_lvl);
      run_to(175);
      step(1'b1, 16'h2222, 4'h0, blz_lvl);
      run_to(192);
      bad = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (nibble !== 4'h2) bad = 1'b1;
         step(1'b0, 16'h0, 4'h0, blz_lvl);
      end
      cmp("last_load_wins", bad, 1'b0);

      // Load on the wrap cycle itself.
      run_to(255);
      step(1'b1, 16'h5555, 4'h0, blz_lvl);
      cmp("wrap_bypass_nibble", nibble, 4'h5);

      // Leading-zero blanking.
      blz_lvl = 1'b1;
      run_to(260);
      step(1'b1, 16'h0040, 4'h0, blz_lvl);
      run_to(288);
      en_seen = 4'h0;
      for (int i = 0; i < 32; i++) begin
         en_seen = en_seen | digit_en;
         step(1'b0, 16'h0, 4'h0, blz_lvl);
      end
      cmp("lz_0040_enables", en_seen, 4'b0011);
      run_to(330);
      step(1'b1, 16'h0000, 4'h0, blz_lvl);
      run_to(352);
      en_seen = 4'h0;
      for (int i = 0; i < 32; i++) begin
         en_seen = en_seen | digit_en;
         step(1'b0, 16'h0, 4'h0, blz_lvl);
      end
      cmp("lz_0000_enables", en_seen, 4'b0001);

      // Reset in the middle of a digit-2 slot with a load pending.
      blz_lvl = 1'b0;
      run_to(390);
      step(1'b1, 16'h7777, 4'b1010, blz_lvl);
      run_to(404);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("async_rst_digit_en", digit_en, 4'h0);
      do_reset();
      bad = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (nibble !== 4'h0 || dp !== 1'b0) bad = 1'b1;
         step(1'b0, 16'h0, 4'h0, blz_lvl);
      end
      cmp("pending_discarded", bad, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 49) == 0) blz_lvl = ~blz_lvl;
         step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom), blz_lvl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
